// File: rtl/matmul2_stream_ctrl.sv
// Stream front/back-end for a combinational 2x2 Q2.14 multiplier.
// Loads A/B operands word by word, captures C, streams C out.
module matmul2_stream_ctrl #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic [DW-1:0] a00,
  output logic [DW-1:0] a01,
  output logic [DW-1:0] a10,
  output logic [DW-1:0] a11,
  output logic [DW-1:0] b00,
  output logic [DW-1:0] b01,
  output logic [DW-1:0] b10,
  output logic [DW-1:0] b11,
  input  logic [DW-1:0] c00,
  input  logic [DW-1:0] c01,
  input  logic [DW-1:0] c10,
  input  logic [DW-1:0] c11,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t        state;
  state_t        nstate;
  logic [2:0]    ld_cnt;
  logic [1:0]    sd_cnt;
  logic [DW-1:0] opnd [8];
  logic [DW-1:0] res  [4];
  logic          s_acc;
  logic          m_acc;

  assign s_acc = s_valid & s_ready;
  assign m_acc = m_valid & m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      LOAD: if (s_acc && ld_cnt == 3'd7) nstate = CALC;
      CALC: nstate = SEND;
      SEND: if (m_acc && sd_cnt == 2'd3) nstate = LOAD;
      default: nstate = LOAD;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    unique case (state)
      LOAD: s_ready = 1'b1;
      SEND: begin
        m_valid = 1'b1;
        m_last  = (sd_cnt == 2'd3);
      end
      default: ;
    endcase
  end

  // load count wraps 7->0 on its own, send count 3->0 likewise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt <= '0;
      sd_cnt <= '0;
    end else begin
      if (s_acc)         ld_cnt <= ld_cnt + 3'd1;
      if (state == CALC) sd_cnt <= '0;
      else if (m_acc)    sd_cnt <= sd_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) opnd[i] <= '0;
    end else if (s_acc) begin
      opnd[ld_cnt] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) res[i] <= '0;
    end else if (state == CALC) begin
      res[0] <= c00;
      res[1] <= c01;
      res[2] <= c10;
      res[3] <= c11;
    end
  end

  assign a00 = opnd[0];
  assign a01 = opnd[1];
  assign a10 = opnd[2];
  assign a11 = opnd[3];
  assign b00 = opnd[4];
  assign b01 = opnd[5];
  assign b10 = opnd[6];
  assign b11 = opnd[7];

  assign m_data = m_valid ? res[sd_cnt] : '0;
  assign busy   = (state != LOAD) || (ld_cnt != 3'd0);

endmodule

// File: tb/tb_matmul2_stream_ctrl.sv
// Scoreboard bench for matmul2_stream_ctrl with a behavioural
// multiplier on the operand/result ports.
module tb_matmul2_stream_ctrl;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [DW-1:0] a00, a01, a10, a11;
  logic [DW-1:0] b00, b01, b10, b11;
  logic [DW-1:0] c00, c01, c10, c11;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic          busy;

  always #5 clk = ~clk;

  matmul2_stream_ctrl #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .a00(a00), .a01(a01), .a10(a10), .a11(a11),
    .b00(b00), .b01(b01), .b10(b10), .b11(b11),
    .c00(c00), .c01(c01), .c10(c10), .c11(c11),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .busy(busy)
  );

  function automatic logic [15:0] dot(
    input logic [15:0] x0, input logic [15:0] y0,
    input logic [15:0] x1, input logic [15:0] y1);
    int p0;
    int p1;
    int s;
    p0 = ($signed(x0) * $signed(y0)) >>> 14;
    p1 = ($signed(x1) * $signed(y1)) >>> 14;
    s  = p0 + p1;
    return s[15:0];
  endfunction

  assign c00 = dot(a00, b00, a01, b10);
  assign c01 = dot(a00, b01, a01, b11);
  assign c10 = dot(a10, b00, a11, b10);
  assign c11 = dot(a10, b01, a11, b11);

  typedef struct {
    logic [15:0] d;
    logic        last;
  } exp_t;

  exp_t        sbq [$];
  logic [15:0] mw [8];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          first_acc;
  int          last_hs = -1;
  int          rmode = 0;
  int          pcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, req, $time);
    end
  endtask

  task automatic push_exp(input int v, input bit l);
    exp_t e;
    e.d    = v[15:0];
    e.last = l;
    sbq.push_back(e);
  endtask

  // Reference: C = A*B over Q2.14 entries, each product shifted, 16-bit wrap
  task automatic push_model();
    int a [2][2];
    int b [2][2];
    int acc;
    for (int i = 0; i < 4; i++) begin
      a[i/2][i%2] = $signed(mw[i]);
      b[i/2][i%2] = $signed(mw[i+4]);
    end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        acc = 0;
        for (int k = 0; k < 2; k++) acc += (a[r][k] * b[k][c]) >>> 14;
        push_exp(acc, (r == 1) && (c == 1));
      end
  endtask

  task automatic rand_mw();
    for (int i = 0; i < 8; i++) mw[i] = 16'($urandom_range(65535));
  endtask

  task automatic chk_ops(input logic [15:0] req [8]);
    logic [15:0] o [8];
    o = '{a00, a01, a10, a11, b00, b01, b10, b11};
    for (int i = 0; i < 8; i++) chk($sformatf("operand%0d", i), o[i], req[i]);
  endtask

  task automatic chk_reset_vals();
    logic [15:0] z [8];
    for (int i = 0; i < 8; i++) z[i] = '0;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk_ops(z);
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic load_matrix(input int nw, input int gap_pct,
                             input bit use_model, input bit chk_lat);
    bit acc;
    int to;
    for (int i = 0; i < nw; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = mw[i];
      acc = 0;
      to  = 0;
      while (!acc) begin
        @(negedge clk);
        if (s_ready) begin
          acc = 1;
          if (i == 0) first_acc = cyc + 1;
        end
        @(posedge clk); #1;
        to++;
        if (to > 2000) begin
          $display("FAIL load_timeout word=%0d", i);
          $fatal(1, "load timeout");
        end
      end
    end
    s_valid = 1'b0;
    if (nw == 8 && use_model) push_model();
    if (nw == 8 && chk_lat) begin
      @(negedge clk);
      chk("calc_m_valid", m_valid, 0);
      chk("calc_s_ready", s_ready, 0);
      chk("calc_busy", busy, 1);
      chk_ops(mw);
      @(negedge clk);
      chk("first_m_valid", m_valid, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int to = 0;
    while (sbq.size() != 0 && to < 2000) begin
      @(posedge clk);
      to++;
    end
    chk("drain_left", sbq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom_range(1));
      default: begin
        m_ready = (pcnt % 3 == 0);
        pcnt++;
      end
    endcase
  end

  logic        stl;
  logic [15:0] pd;
  logic        pl;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      stl = 1'b0;
    end else begin
      if (m_valid) chk("s_ready_in_send", s_ready, 0);
      if (stl) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, pd);
        chk("stall_last", m_last, pl);
      end
      if (m_valid && m_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("m_data", m_data, e.d);
          chk("m_last", m_last, e.last);
        end
        if (m_last) last_hs = cyc + 1;
      end
      stl = m_valid && !m_ready;
      pd  = m_data;
      pl  = m_last;
    end
  end

  task automatic identity(input bit lat);
    mw = '{16'd16384, 16'd0, 16'd0, 16'd16384,
           16'd1000, -16'sd2000, 16'd3000, -16'sd4000};
    push_exp(1000, 0);
    push_exp(-2000, 0);
    push_exp(3000, 0);
    push_exp(-4000, 1);
    load_matrix(8, 0, 0, lat);
    drain();
  endtask

  int b2b_start;
  int b2b_hs1;

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    #12;
    chk_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    identity(1);

    mw = '{8{16'd8192}};
    for (int i = 0; i < 4; i++) push_exp(8192, i == 3);
    load_matrix(8, 0, 0, 1);
    drain();

    mw = '{-16'sd16384, 16'd0, 16'd0, -16'sd16384,
           16'd16384, 16'd8192, -16'sd8192, 16'd4096};
    push_exp(-16384, 0);
    push_exp(-8192, 0);
    push_exp(8192, 0);
    push_exp(-4096, 1);
    load_matrix(8, 0, 0, 1);
    drain();

    rmode = 2;
    pcnt  = 1;
    rand_mw();
    load_matrix(8, 0, 1, 0);
    drain();
    rmode = 0;
    @(posedge clk); #1;

    rand_mw();
    load_matrix(8, 0, 1, 0);
    b2b_start = first_acc;
    rand_mw();
    s_valid = 1'b1;
    load_matrix(8, 0, 1, 0);
    b2b_hs1 = last_hs;
    chk("b2b_next_accept", first_acc, b2b_hs1 + 1);
    drain();
    chk("b2b_cycles", last_hs - b2b_start + 1, 26);

    rmode = 1;
    for (int n = 0; n < 20; n++) begin
      rand_mw();
      load_matrix(8, 30, 1, 0);
    end
    drain();
    rmode = 0;
    @(posedge clk); #1;

    rand_mw();
    load_matrix(5, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    chk_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    identity(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul2_stream_ctrl.md
# matmul2_stream_ctrl

- Stream front/back-end for the combinational 2x2 Q2.14 matrix multiplier.
- Deserialises a valid/ready word stream into registered A and B operand matrices and drives them onto the multiplier operand ports.
- Samples the four result entries in a dedicated compute cycle, then serialises them onto an output valid/ready stream.
- Sits directly upstream and downstream of the multiplier; one matrix product in flight at a time.

## Interface
- DW, 16, word width of every stream word, operand and result (Q2.14 signed)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  input word valid
- s_data  in  DW  input word, signed Q2.14
- s_ready  out  1  input word accepted when s_valid & s_ready at clk edge
- a00, a01, a10, a11  out  DW each  registered A operands to multiplier
- b00, b01, b10, b11  out  DW each  registered B operands to multiplier
- c00, c01, c10, c11  in  DW each  multiplier results (combinational from a*/b*)
- m_valid  out  1  output word valid
- m_data  out  DW  output word
- m_last  out  1  high with the C11 word
- m_ready  in  1  output word consumed when m_valid & m_ready at clk edge
- busy  out  1  high in any state except LOAD with load count 0

## Operation
- States: LOAD, CALC, SEND. Reset state LOAD, load count 0, send count 0.
- LOAD: s_ready=1. Each accepted word is written to the operand register selected by load count 0..7 in order A00, A01, A10, A11, B00, B01, B10, B11. Count increments per accept. On accept of word 7 the count returns to 0 and the state goes to CALC.
- CALC: exactly one cycle, s_ready=0. Register c00..c11 into four internal result registers, go to SEND with send count 0.
- SEND: m_valid=1, m_data = result register at send count (C00, C01, C10, C11). Send count increments per handshake. m_last=1 only while send count = 3. Handshake at count 3 returns the state to LOAD.
- Operand registers hold their value after CALC until overwritten by the next LOAD. Partially loaded next-matrix words overwrite in place; no double-buffering.
- s_ready=0 in CALC and SEND. Input words offered then are not consumed and must be held by the upstream.
- m_data, m_last hold stable while m_valid=1 and m_ready=0.
- No arithmetic in this block. Results pass bit-exact from the multiplier (per-product arithmetic shift by 14, 16-bit wrap, no saturation).
- busy drops with the final SEND handshake.
- Reset at any time, including mid-LOAD or mid-SEND: all state, counters and registers clear asynchronously. The partial matrix is discarded. The first post-reset word is A00.

## Timing
- Reset values: s_ready=1, m_valid=0, m_last=0, m_data=0, busy=0, all a*/b* outputs=0.
- Operand register updates on the edge that accepts its word; the multiplier sees it the next cycle.
- Word 7 accepted at edge k: CALC during cycle k..k+1, results captured at edge k+1. m_valid=1 with C00 from edge k+1.
- With m_ready held 1, C00..C11 occupy 4 consecutive cycles. s_ready returns to 1 the cycle after the C11 handshake.
- Minimum period per matrix with s_valid and m_ready held 1: 8 load + 1 calc + 4 send = 13 cycles.
- s_valid or m_ready gaps stall the relevant counter only. State does not change without a handshake, except CALC to SEND.

## Test plan
- Identity: A=16384,0,0,16384; B=1000,-2000,3000,-4000 -> output 1000, -2000, 3000, -4000; m_last on the 4th word; m_valid first high exactly 1 cycle after the 8th accept.
- Halves: all A=8192, all B=8192 -> every C = 4096+4096 = 8192.
- Signed: A=-16384,0,0,-16384; B=16384,8192,-8192,4096 -> output -16384, -8192, 8192, -4096.
- Backpressure: m_ready toggling 1,0,0,1,... during SEND -> m_data/m_last stable while stalled; each word emitted exactly once; s_ready=0 throughout CALC and SEND.
- Back-to-back: two 8-word matrices offered with s_valid always 1 -> the second matrix's first word is accepted the cycle after the first C11 handshake; both products correct; 26 cycles total at m_ready=1.
- Reset mid-load: assert rst_n=0 after 5 words, release, send a full fresh 8-word identity case -> correct result; outputs equal reset values during reset.
